// File: rtl/uart_sseg_cmd_rx_pkg.sv
// ============================================================================
// Module      : uart_sseg_cmd_rx_pkg
// Description : ASCII constants, FSM encoding and digit-enable values shared
//               by the UART seven-segment command receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_sseg_cmd_rx_pkg;

    localparam logic [7:0] c_ascii_d_up = 8'h44;
    localparam logic [7:0] c_ascii_d_lo = 8'h64;
    localparam logic [7:0] c_ascii_c_up = 8'h43;
    localparam logic [7:0] c_ascii_c_lo = 8'h63;
    localparam logic [7:0] c_ascii_cr   = 8'h0D;
    localparam logic [7:0] c_ascii_lf   = 8'h0A;
    localparam logic [7:0] c_ascii_ack  = 8'h4B;
    localparam logic [7:0] c_ascii_nak  = 8'h3F;

    localparam logic [7:0] c_digit_en_all  = 8'hFF;
    localparam logic [7:0] c_digit_en_none = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIGITS  = 2'd1,
        ST_WAIT_CR = 2'd2,
        ST_ISSUE   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bin2sseg.sv
// ============================================================================
// Module      : bin2sseg
// Description : Nibble to seven-segment pattern, {dp,g,f,e,d,c,b,a}, active high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2sseg (
    input  logic [3:0] bin,
    output logic [7:0] seg
);

    always_comb begin
        seg = 8'h00;
        case (bin)
            4'h0: seg = 8'h3F;
            4'h1: seg = 8'h06;
            4'h2: seg = 8'h5B;
            4'h3: seg = 8'h4F;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'h6D;
            4'h6: seg = 8'h7D;
            4'h7: seg = 8'h07;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h6F;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h7C;
            4'hC: seg = 8'h39;
            4'hD: seg = 8'h5E;
            4'hE: seg = 8'h79;
            4'hF: seg = 8'h71;
            default: seg = 8'h00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/uart_sseg_cmd_rx_hex_decode.sv
// ============================================================================
// Module      : ascii_hex_decode
// Description : Combinational ASCII hex character to nibble decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascii_hex_decode (
    input  logic [7:0] data,
    output logic [3:0] nibble,
    output logic       is_hex
);

    always_comb begin
        nibble = 4'h0;
        is_hex = 1'b0;
        if (data >= 8'h30 && data <= 8'h39) begin
            nibble = data[3:0];
            is_hex = 1'b1;
        end else if ((data >= 8'h41 && data <= 8'h46) ||
                     (data >= 8'h61 && data <= 8'h66)) begin
            // 'A'/'a' carry 1 in the low nibble, so +9 lands on 10
            nibble = data[3:0] + 4'd9;
            is_hex = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_sseg_cmd_rx.sv
// ============================================================================
// Module      : uart_sseg_cmd_rx
// Description : Parses host ASCII frames ("D"+8 hex+CR, "C"+CR) and loads the
//               seven-segment controller. Optional ACK/NAK: UART_SSEG_CMD_ACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sseg_cmd_rx
    import uart_sseg_cmd_rx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        ss_idle,
    input  logic        tx_busy,
    output logic [63:0] ss_data,
    output logic [7:0]  ss_digit_en,
    output logic        ss_start,
    output logic        host_active,
    output logic        err,
    output logic        tx_start,
    output logic [7:0]  tx_data
);

    localparam int              c_to_w    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_cnt;
    logic [2:0]          w_cnt_next;
    logic [2:0]          w_slot;
    logic [31:0]         r_nib;
    logic [31:0]         w_nib_next;
    logic                r_clear;
    logic                w_clear_next;
    logic [c_to_w-1:0]   r_to_cnt;
    logic                w_to_expired;
    logic                w_err_next;
    logic                w_issue;
    logic [3:0]          w_hex_nib;
    logic                w_is_hex;
    logic [63:0]         w_seg;

    logic [63:0]         r_ss_data;
    logic [7:0]          r_ss_digit_en;
    logic                r_ss_start;
    logic                r_host_active;
    logic                r_err;

    ascii_hex_decode u_hex (
        .data   (rx_data),
        .nibble (w_hex_nib),
        .is_hex (w_is_hex)
    );

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_seg
            bin2sseg u_b2s (
                .bin (r_nib[4*gi +: 4]),
                .seg (w_seg[8*gi +: 8])
            );
        end
    endgenerate

    assign w_slot       = 3'd7 - r_cnt;
    assign w_to_expired = (r_to_cnt == c_to_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_nib_next   = r_nib;
        w_clear_next = r_clear;
        w_err_next   = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == c_ascii_d_up || rx_data == c_ascii_d_lo) begin
                        w_state_next = ST_DIGITS;
                        w_cnt_next   = 3'd0;
                        w_clear_next = 1'b0;
                    end else if (rx_data == c_ascii_c_up || rx_data == c_ascii_c_lo) begin
                        w_state_next = ST_WAIT_CR;
                        w_clear_next = 1'b1;
                    end else if (rx_data != c_ascii_cr && rx_data != c_ascii_lf) begin
                        w_err_next = 1'b1;
                    end
                end
            end
            ST_DIGITS: begin
                if (rx_valid) begin
                    if (w_is_hex) begin
                        w_nib_next[{w_slot, 2'b00} +: 4] = w_hex_nib;
                        w_cnt_next = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_state_next = ST_WAIT_CR;
                        end
                    end else begin
                        w_err_next   = 1'b1;
                        w_nib_next   = '0;
                        w_state_next = ST_IDLE;
                    end
                end else if (w_to_expired) begin
                    w_err_next   = 1'b1;
                    w_nib_next   = '0;
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT_CR: begin
                if (rx_valid) begin
                    if (rx_data == c_ascii_cr) begin
                        w_state_next = ST_ISSUE;
                    end else begin
                        w_err_next   = 1'b1;
                        w_nib_next   = '0;
                        w_state_next = ST_IDLE;
                    end
                end else if (w_to_expired) begin
                    w_err_next   = 1'b1;
                    w_nib_next   = '0;
                    w_state_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // The controller handshake has no timeout; only stray bytes are flagged
                w_err_next = rx_valid;
                if (ss_idle) begin
                    w_issue      = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 3'd0;
            r_nib    <= '0;
            r_clear  <= 1'b0;
            r_to_cnt <= '0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_nib   <= w_nib_next;
            r_clear <= w_clear_next;
            if ((r_state == ST_DIGITS || r_state == ST_WAIT_CR) &&
                !rx_valid && !w_to_expired) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ss_data     <= '0;
            r_ss_digit_en <= c_digit_en_none;
            r_ss_start    <= 1'b0;
            r_host_active <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_ss_start <= w_issue;
            r_err      <= w_err_next;
            if (w_issue) begin
                if (r_clear) begin
                    r_ss_digit_en <= c_digit_en_none;
                    r_host_active <= 1'b0;
                end else begin
                    r_ss_data     <= w_seg;
                    r_ss_digit_en <= c_digit_en_all;
                    r_host_active <= 1'b1;
                end
            end
        end
    end

    assign ss_data     = r_ss_data;
    assign ss_digit_en = r_ss_digit_en;
    assign ss_start    = r_ss_start;
    assign host_active = r_host_active;
    assign err         = r_err;

`ifdef UART_SSEG_CMD_ACK_EN
    logic       r_ack_pend;
    logic       r_nak_pend;
    logic       r_tx_start;
    logic [7:0] r_tx_data;
    logic       w_send_ack;
    logic       w_send_nak;

    // Holding off for one cycle after a start covers the transmitter's busy latency
    assign w_send_ack = r_ack_pend & ~tx_busy & ~r_tx_start;
    assign w_send_nak = r_nak_pend & ~r_ack_pend & ~tx_busy & ~r_tx_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack_pend <= 1'b0;
            r_nak_pend <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_ack_pend <= (r_ack_pend & ~w_send_ack) | r_ss_start;
            r_nak_pend <= (r_nak_pend & ~w_send_nak) | r_err;
            r_tx_start <= w_send_ack | w_send_nak;
            if (w_send_ack) begin
                r_tx_data <= c_ascii_ack;
            end else if (w_send_nak) begin
                r_tx_data <= c_ascii_nak;
            end
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
`else
    logic w_unused_tx_busy;

    assign w_unused_tx_busy = tx_busy;
    assign tx_start         = 1'b0;
    assign tx_data          = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_sseg_cmd_rx.sv
// ============================================================================
// Module      : tb_uart_sseg_cmd_rx
// Description : Directed, table-driven bench for uart_sseg_cmd_rx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_sseg_cmd_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        ss_idle;
    logic        tx_busy;
    logic [63:0] ss_data;
    logic [7:0]  ss_digit_en;
    logic        ss_start;
    logic        host_active;
    logic        err;
    logic        tx_start;
    logic [7:0]  tx_data;

    int checks   = 0;
    int failures = 0;
    int start_cnt = 0;
    int err_cnt   = 0;
    int tx_cnt    = 0;
    logic [7:0] tx_log [0:15];

    uart_sseg_cmd_rx #(.TIMEOUT_CYCLES(100)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .ss_idle     (ss_idle),
        .tx_busy     (tx_busy),
        .ss_data     (ss_data),
        .ss_digit_en (ss_digit_en),
        .ss_start    (ss_start),
        .host_active (host_active),
        .err         (err),
        .tx_start    (tx_start),
        .tx_data     (tx_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ss_start) start_cnt = start_cnt + 1;
        if (err) err_cnt = err_cnt + 1;
        if (tx_start) begin
            tx_log[tx_cnt % 16] = tx_data;
            tx_cnt = tx_cnt + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [95:0] str;
        int          len;
        int          exp_start;
        int          exp_err;
        logic [31:0] exp_nib;
        logic [7:0]  exp_en;
        logic        exp_host;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    function automatic logic [7:0] seg7(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'h3F; 4'h1: s = 8'h06; 4'h2: s = 8'h5B; 4'h3: s = 8'h4F;
            4'h4: s = 8'h66; 4'h5: s = 8'h6D; 4'h6: s = 8'h7D; 4'h7: s = 8'h07;
            4'h8: s = 8'h7F; 4'h9: s = 8'h6F; 4'hA: s = 8'h77; 4'hB: s = 8'h7C;
            4'hC: s = 8'h39; 4'hD: s = 8'h5E; 4'hE: s = 8'h79; default: s = 8'h71;
        endcase
        return s;
    endfunction

    function automatic logic [63:0] segs(input logic [31:0] nib);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = seg7(nib[4*i +: 4]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [95:0] s, input int len, input int gap);
        for (int i = 0; i < len; i++) begin
            rx_data  = s[8*(len-1-i) +: 8];
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    initial begin
        int s0, e0, t0, waited;

        vecs[0]  = '{{"D0123ABCD", 8'h0D}, 10, 1, 0, 32'h0123ABCD, 8'hFF, 1'b1};
        vecs[1]  = '{"D12G",               4, 0, 1, 32'h0123ABCD, 8'hFF, 1'b1};
        vecs[2]  = '{"D123456789",        10, 0, 1, 32'h0123ABCD, 8'hFF, 1'b1};
        vecs[3]  = '{{"C", 8'h0D},         2, 1, 0, 32'h0123ABCD, 8'h00, 1'b0};
        vecs[4]  = '{{"d89efEF01", 8'h0D}, 10, 1, 0, 32'h89EFEF01, 8'hFF, 1'b1};
        vecs[5]  = '{{8'h0D, 8'h0A, "X"},  3, 0, 1, 32'h89EFEF01, 8'hFF, 1'b1};
        vecs[6]  = '{"CX",                 2, 0, 1, 32'h89EFEF01, 8'hFF, 1'b1};
        vecs[7]  = '{{"c", 8'h0D},         2, 1, 0, 32'h89EFEF01, 8'h00, 1'b0};
        vecs[8]  = '{{"D4567", 8'h0D},     6, 0, 1, 32'h89EFEF01, 8'h00, 1'b0};
        vecs[9]  = '{{"D9aF0A6f5", 8'h0D}, 10, 1, 0, 32'h9AF0A6F5, 8'hFF, 1'b1};
        vecs[10] = '{"D:",                 2, 0, 1, 32'h9AF0A6F5, 8'hFF, 1'b1};
        vecs[11] = '{"D@",                 2, 0, 1, 32'h9AF0A6F5, 8'hFF, 1'b1};
        vecs[12] = '{"Dg",                 2, 0, 1, 32'h9AF0A6F5, 8'hFF, 1'b1};
        vecs[13] = '{{"D", 8'h60},         2, 0, 1, 32'h9AF0A6F5, 8'hFF, 1'b1};
        vecs[14] = '{"D/",                 2, 0, 1, 32'h9AF0A6F5, 8'hFF, 1'b1};

        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; ss_idle = 1'b1; tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset_ss_data", ss_data, 64'h0);
        check("reset_digit_en", {56'h0, ss_digit_en}, 64'h0);
        check("reset_ss_start", {63'h0, ss_start}, 64'h0);
        check("reset_host_active", {63'h0, host_active}, 64'h0);
        check("reset_err", {63'h0, err}, 64'h0);
        check("reset_tx_start", {63'h0, tx_start}, 64'h0);
        check("reset_tx_data", {56'h0, tx_data}, 64'h0);

        for (int v = 0; v < NV; v++) begin
            s0 = start_cnt; e0 = err_cnt;
            send_frame(vecs[v].str, vecs[v].len, v % 2);
            repeat (6) @(negedge clk);
            check($sformatf("vec%0d_starts", v), 64'(start_cnt - s0), 64'(vecs[v].exp_start));
            check($sformatf("vec%0d_errs", v), 64'(err_cnt - e0), 64'(vecs[v].exp_err));
            check($sformatf("vec%0d_ss_data", v), ss_data, segs(vecs[v].exp_nib));
            check($sformatf("vec%0d_digit_en", v), {56'h0, ss_digit_en}, {56'h0, vecs[v].exp_en});
            check($sformatf("vec%0d_host_active", v), {63'h0, host_active}, {63'h0, vecs[v].exp_host});
        end

        // Exact command latency: CR in N, ss_start and data in N+2
        send_frame("D0000FFFF", 9, 0);
        rx_data = 8'h0D; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("lat_n1_start", {63'h0, ss_start}, 64'h0);
        check("lat_n1_data_hold", ss_data, segs(32'h9AF0A6F5));
        @(negedge clk);
        check("lat_n2_start", {63'h0, ss_start}, 64'h1);
        check("lat_n2_data", ss_data, segs(32'h0000FFFF));
        check("lat_n2_host", {63'h0, host_active}, 64'h1);
        @(negedge clk);
        check("lat_n3_start_low", {63'h0, ss_start}, 64'h0);

        rx_data = "Z"; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("err_next_cycle", {63'h0, err}, 64'h1);
        @(negedge clk);
        check("err_one_cycle", {63'h0, err}, 64'h0);

        // Stalled handshake, with a stray byte dropped while waiting
        ss_idle = 1'b0;
        s0 = start_cnt; e0 = err_cnt;
        send_frame({"Dffffffff", 8'h0D}, 10, 0);
        repeat (60) @(negedge clk);
        send_frame("X", 1, 0);
        repeat (90) @(negedge clk);
        check("stall_no_start", 64'(start_cnt - s0), 64'd0);
        check("stall_stray_err", 64'(err_cnt - e0), 64'd1);
        check("stall_data_hold", ss_data, segs(32'h0000FFFF));
        ss_idle = 1'b1;
        repeat (4) @(negedge clk);
        check("stall_one_start", 64'(start_cnt - s0), 64'd1);
        check("stall_data", ss_data, segs(32'hFFFFFFFF));

        // Inter-byte timeout
        e0 = err_cnt;
        send_frame("D12", 3, 0);
        waited = 0;
        while (!err && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("timeout_latency", 64'(waited), 64'd100);
        repeat (3) @(negedge clk);
        check("timeout_one_err", 64'(err_cnt - e0), 64'd1);
        check("timeout_data_hold", ss_data, segs(32'hFFFFFFFF));
        s0 = start_cnt;
        send_frame({"D76543210", 8'h0D}, 10, 0);
        repeat (5) @(negedge clk);
        check("after_timeout_start", 64'(start_cnt - s0), 64'd1);
        check("after_timeout_data", ss_data, segs(32'h76543210));

        // Reset mid-frame
        send_frame("D1234", 5, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_ss_data", ss_data, 64'h0);
        check("midrst_digit_en", {56'h0, ss_digit_en}, 64'h0);
        check("midrst_host", {63'h0, host_active}, 64'h0);
        check("midrst_err", {63'h0, err}, 64'h0);
        check("midrst_tx_data", {56'h0, tx_data}, 64'h0);
        rst = 1'b0;
        s0 = start_cnt;
        send_frame({"5678", 8'h0D}, 5, 0);
        repeat (5) @(negedge clk);
        check("midrst_no_start", 64'(start_cnt - s0), 64'd0);
        check("midrst_data_zero", ss_data, 64'h0);

`ifdef UART_SSEG_CMD_ACK_EN
        t0 = tx_cnt;
        send_frame({"DABCDEF01", 8'h0D}, 10, 0);
        repeat (6) @(negedge clk);
        check("ack_count", 64'(tx_cnt - t0), 64'd1);
        check("ack_byte", {56'h0, tx_log[t0 % 16]}, 64'h4B);
        t0 = tx_cnt;
        send_frame("X", 1, 0);
        repeat (6) @(negedge clk);
        check("nak_byte", {56'h0, tx_log[t0 % 16]}, 64'h3F);
        tx_busy = 1'b1;
        t0 = tx_cnt;
        send_frame({"D00112233", 8'h0D}, 10, 0);
        repeat (3) @(negedge clk);
        send_frame("X", 1, 0);
        repeat (20) @(negedge clk);
        check("busy_nothing_sent", 64'(tx_cnt - t0), 64'd0);
        tx_busy = 1'b0;
        repeat (10) @(negedge clk);
        check("busy_two_sent", 64'(tx_cnt - t0), 64'd2);
        check("busy_ack_first", {56'h0, tx_log[t0 % 16]}, 64'h4B);
        check("busy_nak_second", {56'h0, tx_log[(t0 + 1) % 16]}, 64'h3F);
`else
        t0 = tx_cnt;
        check("no_ack_tx_count", 64'(t0), 64'd0);
        check("no_ack_tx_data", {56'h0, tx_data}, 64'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
